// File: rtl/s27_array_pkg.sv
// rtl/s27_array_pkg.sv - shared constants and types for the s27_array kernel bundle
package s27_array_pkg;

    localparam int STATE_W = 3;

    // Bit positions of the kernel state flops inside s27_state_t
    localparam int G5_IDX = 2;
    localparam int G6_IDX = 1;
    localparam int G7_IDX = 0;

    typedef logic [STATE_W-1:0] s27_state_t;

endpackage

// File: rtl/s27_core.sv
// rtl/s27_core.sv - one s27 kernel channel: output logic, state, hit counter, optional scan (S27_ARRAY_SCAN_CHAIN_EN)
module s27_core
    import s27_array_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             g0,
    input  logic             g1,
    input  logic             g2,
    input  logic             g3,
`ifdef S27_ARRAY_SCAN_CHAIN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic             g17,
    output s27_state_t       state,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    s27_state_t       state_q;
    s27_state_t       state_d;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] hit_d;

    logic n19;
    logic n20;
    logic n21;
    logic g17_c;

    // Kernel output, purely combinational from inputs and current state
    always_comb begin
        n19   = g0 | ~state_q[G6_IDX];
        n20   = state_q[G7_IDX] | g1;
        n21   = ~g3 | n20;
        g17_c = state_q[G5_IDX] | (n19 & n21);
    end

    // Next state and saturating hit count; scan shift overrides the functional step
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
`ifdef S27_ARRAY_SCAN_CHAIN_EN
        if (scan_en) begin
            // Shift toward G7: G5 takes the incoming bit, G7 falls out to the next channel
            state_d = {scan_in, state_q[G5_IDX], state_q[G6_IDX]};
        end else
`endif
        if (en) begin
            state_d[G5_IDX] = g0 & g17_c;
            state_d[G6_IDX] = ~g17_c;
            state_d[G7_IDX] = ~g2 & n20;
            if (g17_c && (hit_q != CNT_MAX)) begin
                hit_d = hit_q + CNT_ONE;
            end
        end
    end

    // State and counter registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
        end
    end

    assign g17     = g17_c;
    assign state   = state_q;
    assign hit_cnt = hit_q;
`ifdef S27_ARRAY_SCAN_CHAIN_EN
    assign scan_out = state_q[G7_IDX];
`endif

endmodule

// File: rtl/s27_array.sv
// rtl/s27_array.sv - CHANNELS parallel s27 kernels with global step counter, optional scan chain (S27_ARRAY_SCAN_CHAIN_EN)
module s27_array
    import s27_array_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int CYC_W    = 16
) (
    input  logic                        blif_clk_net,
    input  logic                        blif_reset_net,
    input  logic                        en,
    input  logic [CHANNELS-1:0]         g0,
    input  logic [CHANNELS-1:0]         g1,
    input  logic [CHANNELS-1:0]         g2,
    input  logic [CHANNELS-1:0]         g3,
`ifdef S27_ARRAY_SCAN_CHAIN_EN
    input  logic                        scan_en,
    input  logic                        scan_in,
    output logic                        scan_out,
`endif
    output logic [CHANNELS-1:0]         g17,
    output logic [STATE_W*CHANNELS-1:0] state_q,
    output logic [CNT_W*CHANNELS-1:0]   hit_cnt,
    output logic [CYC_W-1:0]            cycle_cnt
);

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    logic [CYC_W-1:0] cycle_cnt_q;
    logic [CYC_W-1:0] cycle_cnt_d;

`ifdef S27_ARRAY_SCAN_CHAIN_EN
    // scan_link[i] feeds channel i; channel 0 G5 is the head, last channel G7 the tail
    logic [CHANNELS:0] scan_link;
    assign scan_link[0] = scan_in;
    assign scan_out     = scan_link[CHANNELS];
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        s27_core #(
            .CNT_W (CNT_W)
        ) u_core (
            .clk      (blif_clk_net),
            .rst      (blif_reset_net),
            .en       (en),
            .g0       (g0[i]),
            .g1       (g1[i]),
            .g2       (g2[i]),
            .g3       (g3[i]),
`ifdef S27_ARRAY_SCAN_CHAIN_EN
            .scan_en  (scan_en),
            .scan_in  (scan_link[i]),
            .scan_out (scan_link[i+1]),
`endif
            .g17      (g17[i]),
            .state    (state_q[STATE_W*i +: STATE_W]),
            .hit_cnt  (hit_cnt[CNT_W*i +: CNT_W])
        );
    end

    // Global enabled-step counter, wraps naturally; frozen while scanning
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
`ifdef S27_ARRAY_SCAN_CHAIN_EN
        if (!scan_en && en) begin
            cycle_cnt_d = cycle_cnt_q + CYC_ONE;
        end
`else
        if (en) begin
            cycle_cnt_d = cycle_cnt_q + CYC_ONE;
        end
`endif
    end

    // Cycle counter register
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_s27_array.sv
// tb/tb_s27_array.sv - scoreboard bench for s27_array, scan section under S27_ARRAY_SCAN_CHAIN_EN
module tb_s27_array;

    localparam int CH   = 4;
    localparam int CW   = 4;
    localparam int YW   = 4;
    localparam int HMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [CH-1:0]     g0, g1, g2, g3;
    logic [CH-1:0]     g17;
    logic [3*CH-1:0]   state_q;
    logic [CW*CH-1:0]  hit_cnt;
    logic [YW-1:0]     cycle_cnt;
`ifdef S27_ARRAY_SCAN_CHAIN_EN
    logic              scan_en = 1'b0;
    logic              scan_in = 1'b0;
    logic              scan_out;
`endif

    s27_array #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .CYC_W    (YW)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .en             (en),
        .g0             (g0),
        .g1             (g1),
        .g2             (g2),
        .g3             (g3),
`ifdef S27_ARRAY_SCAN_CHAIN_EN
        .scan_en        (scan_en),
        .scan_in        (scan_in),
        .scan_out       (scan_out),
`endif
        .g17            (g17),
        .state_q        (state_q),
        .hit_cnt        (hit_cnt),
        .cycle_cnt      (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3*CH-1:0]  st;
        logic [CW*CH-1:0] hit;
        logic [YW-1:0]    cyc;
    } exp_t;

    exp_t        sb[$];
    logic [2:0]  m_st [CH];
    int          m_hit [CH];
    int          m_cyc;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_g17(input logic [2:0] s, input logic a0, input logic a1, input logic a3);
        return s[2] | ((a0 | ~s[1]) & (~a3 | (s[0] | a1)));
    endfunction

    // One clock: drive, check g17 now, push expected post-edge values, pop after the edge
    task automatic step(input logic r, input logic e, input logic [CH-1:0] a0, input logic [CH-1:0] a1,
                        input logic [CH-1:0] a2, input logic [CH-1:0] a3);
        exp_t          x;
        logic [CH-1:0] eg;
        rst = r; en = e; g0 = a0; g1 = a1; g2 = a2; g3 = a3;
        #1;
        for (int c = 0; c < CH; c++) eg[c] = ref_g17(m_st[c], a0[c], a1[c], a3[c]);
        check("g17", 64'(g17), 64'(eg));
        for (int c = 0; c < CH; c++) begin
            if (r) begin
                m_st[c]  = 3'b000;
                m_hit[c] = 0;
            end else if (e) begin
                if (eg[c] && m_hit[c] < HMAX) m_hit[c]++;
                m_st[c] = {a0[c] & eg[c], ~eg[c], ~a2[c] & (m_st[c][0] | a1[c])};
            end
        end
        if (r) m_cyc = 0;
        else if (e) m_cyc = (m_cyc + 1) % (1 << YW);
        for (int c = 0; c < CH; c++) begin
            x.st[3*c +: 3]   = m_st[c];
            x.hit[CW*c +: CW] = m_hit[c][CW-1:0];
        end
        x.cyc = m_cyc[YW-1:0];
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("state_q", 64'(state_q), 64'(x.st));
        check("hit_cnt", 64'(hit_cnt), 64'(x.hit));
        check("cycle_cnt", 64'(cycle_cnt), 64'(x.cyc));
    endtask

    initial begin
        logic [11:0] pat;
        for (int c = 0; c < CH; c++) begin
            m_st[c]  = 3'b000;
            m_hit[c] = 0;
        end
        m_cyc = 0;
        rst = 1'b1; en = 1'b0; g0 = '0; g1 = '0; g2 = '0; g3 = '0;
        @(posedge clk);
        #1;

        // Reset state and post-reset g17 = ~G3 | G1
        step(1'b1, 1'b0, '0, '0, '0, '0);
        check("rst_state", 64'(state_q), 64'd0);
        check("rst_hit", 64'(hit_cnt), 64'd0);
        check("rst_cyc", 64'(cycle_cnt), 64'd0);
        g3 = 4'b0101; g1 = 4'b0001;
        #1;
        check("rst_g17", 64'(g17), 64'(4'b1011));

        // G0=1 G1=0 G2=0 G3=0
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        check("t1_state", 64'(state_q[2:0]), 64'(3'b100));
        check("t1_g17", 64'(g17[0]), 64'd1);
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        check("t1_hit", 64'(hit_cnt[CW-1:0]), 64'd3);
        check("t1_cyc", 64'(cycle_cnt), 64'd3);

        // G0=1 G1=0 G2=0 G3=1
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'hF);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF);
        check("t2_state", 64'(state_q[2:0]), 64'(3'b010));
        check("t2_g17", 64'(g17[0]), 64'd0);
        check("t2_hit", 64'(hit_cnt[CW-1:0]), 64'd0);

        // G0=0 G1=1 G2=0 G3=1
        step(1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF);
        step(1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'hF);
        check("t3_state", 64'(state_q[2:0]), 64'(3'b001));

        // Saturation of hit_cnt and wrap of cycle_cnt over 20 steps
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        check("sat_hit", 64'(hit_cnt[CW-1:0]), 64'd15);
        check("wrap_cyc", 64'(cycle_cnt), 64'd4);

        // en=0 holds everything regardless of inputs
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, CH'($urandom), CH'($urandom), CH'($urandom), CH'($urandom));
        check("hold_state", 64'(state_q[2:0]), 64'(3'b100));
        check("hold_hit", 64'(hit_cnt[CW-1:0]), 64'd15);
        check("hold_cyc", 64'(cycle_cnt), 64'd4);

        // Reset wins over en mid-run
        step(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        check("mid_rst_state", 64'(state_q), 64'd0);
        check("mid_rst_hit", 64'(hit_cnt), 64'd0);
        check("mid_rst_cyc", 64'(cycle_cnt), 64'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 CH'($urandom), CH'($urandom), CH'($urandom), CH'($urandom));

`ifdef S27_ARRAY_SCAN_CHAIN_EN
        step(1'b1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        pat = 12'hA5C;
        // Shift in LSB first with en held high; functional path must be ignored
        rst = 1'b0; en = 1'b1; scan_en = 1'b1;
        for (int k = 0; k < 3*CH; k++) begin
            scan_in = pat[k];
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < CH; c++) begin
            check("scan_state", 64'(state_q[3*c +: 3]), 64'(pat[11-3*c -: 3]));
            check("scan_hit", 64'(hit_cnt[CW*c +: CW]), 64'd3);
        end
        check("scan_cyc", 64'(cycle_cnt), 64'd3);
        scan_in = 1'b0;
        for (int k = 0; k < 3*CH; k++) begin
            check("scan_out", 64'(scan_out), 64'(pat[k]));
            @(posedge clk);
            #1;
        end
        check("scan_flush", 64'(state_q), 64'd0);
        scan_en = 1'b0;
        for (int c = 0; c < CH; c++) m_st[c] = 3'b000;
        step(1'b1, 1'b1, '0, '0, '0, '0);
`else
        pat = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
